alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ clients.
// Optional response timeout is compiled in when ALU_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [4*NUM_REQ-1:0]         req_opcode,
  input  logic [BUS_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [BUS_WIDTH*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]           req_carry_in,
  output logic [3:0]                   alu_opcode,
  output logic [BUS_WIDTH-1:0]         alu_a,
  output logic [BUS_WIDTH-1:0]         alu_b,
  output logic                         alu_carry_in,
  input  logic [BUS_WIDTH-1:0]         alu_y,
  input  logic [4:0]                   alu_flags,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [BUS_WIDTH-1:0]         rsp_y,
  output logic [4:0]                   rsp_flags
`ifdef ALU_ARB_TIMEOUT_EN
  ,
  output logic                         rsp_timeout
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_chk
    $error("alu_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [3:0]           op_q, op_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic                 cin_q, cin_d;
  logic [BUS_WIDTH-1:0] y_q, y_d;
  logic [4:0]           fl_q, fl_d;

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0]           cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
`endif

  logic                 found;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        gnt_nxt;
  logic                 hs;
  logic                 rsp_hs;

  // First valid requester searching upward from ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign gnt_nxt = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + PW'(1);
  assign hs      = (state_q == IDLE) && found && !rst;
  assign rsp_hs  = (state_q == RESP) && rsp_ready[gnt_q];

  assign req_ready = hs ? (NUM_REQ'(1) << sel) : '0;
  assign rsp_valid = ((state_q == RESP) && !rst) ?
                     (NUM_REQ'(1) << gnt_q) : '0;

  assign alu_opcode   = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_carry_in = cin_q;
  assign rsp_y        = y_q;
  assign rsp_flags    = fl_q;

`ifdef ALU_ARB_TIMEOUT_EN
  assign rsp_timeout = tmo_q;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    y_d     = y_q;
    fl_d    = fl_q;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d   = '0;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = EXEC;
          gnt_d   = sel;
          op_d    = req_opcode[int'(sel)*4 +: 4];
          a_d     = req_a[int'(sel)*BUS_WIDTH +: BUS_WIDTH];
          b_d     = req_b[int'(sel)*BUS_WIDTH +: BUS_WIDTH];
          cin_d   = req_carry_in[sel];
        end
      end
      EXEC: begin
        y_d     = alu_y;
        fl_d    = alu_flags;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
          ptr_d   = gnt_nxt;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          ptr_d   = gnt_nxt;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      y_q     <= '0;
      fl_q    <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      y_q     <= y_d;
      fl_q    <= fl_d;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule
